// File: rtl/ram_port_arbiter.sv
// ============================================================================
// ram_port_arbiter : dual round-robin arbiter in front of a 256x8 dual-port RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_port_arbiter #(
   parameter  int DEPTH  = 256,
   parameter  int DWIDTH = 8,
   localparam int AWIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            wr_req,
   input  logic [2*AWIDTH-1:0]   wr_addr_i,
   input  logic [2*DWIDTH-1:0]   wr_data_i,
   output logic [1:0]            wr_gnt,
   input  logic [1:0]            rd_req,
   input  logic [2*AWIDTH-1:0]   rd_addr_i,
   output logic [1:0]            rd_gnt,
   output logic [1:0]            rd_valid,
   output logic [DWIDTH-1:0]     rd_data_o,
   output logic                  ram_wr_enbl,
   output logic [AWIDTH-1:0]     ram_wr_addr,
   output logic [DWIDTH-1:0]     ram_wr_data,
   output logic                  ram_rd_enbl,
   output logic [AWIDTH-1:0]     ram_rd_addr,
   input  logic [DWIDTH-1:0]     ram_rd_data
);

   logic              wr_last_q, wr_last_d;
   logic              rd_last_q, rd_last_d;
   logic              ram_wr_enbl_q, ram_wr_enbl_d;
   logic [AWIDTH-1:0] ram_wr_addr_q, ram_wr_addr_d;
   logic [DWIDTH-1:0] ram_wr_data_q, ram_wr_data_d;
   logic              ram_rd_enbl_q, ram_rd_enbl_d;
   logic [AWIDTH-1:0] ram_rd_addr_q, ram_rd_addr_d;
   logic              rd_own1_q, rd_own1_d;
   logic [1:0]        rd_valid_q, rd_valid_d;
   logic [DWIDTH-1:0] rd_hold_q, rd_hold_d;

   logic              w_wr_sel, w_rd_sel;
   logic              w_wr_go, w_rd_go, w_hazard;
   logic [AWIDTH-1:0] w_wr_addr, w_rd_addr;
   logic [DWIDTH-1:0] w_wr_data;

   // Candidate selection: a lone requester wins, otherwise the one not served last.
   always_comb begin
      w_wr_sel  = (&wr_req) ? ~wr_last_q : wr_req[1];
      w_rd_sel  = (&rd_req) ? ~rd_last_q : rd_req[1];
      w_wr_addr = w_wr_sel ? wr_addr_i[2*AWIDTH-1:AWIDTH] : wr_addr_i[AWIDTH-1:0];
      w_wr_data = w_wr_sel ? wr_data_i[2*DWIDTH-1:DWIDTH] : wr_data_i[DWIDTH-1:0];
      w_rd_addr = w_rd_sel ? rd_addr_i[2*AWIDTH-1:AWIDTH] : rd_addr_i[AWIDTH-1:0];
      w_wr_go   = (|wr_req) & ~rst;
      // A read to the address being written this cycle would see stale data.
      w_hazard  = w_wr_go & (w_rd_addr == w_wr_addr);
      w_rd_go   = (|rd_req) & ~rst & ~w_hazard;
      wr_gnt    = {w_wr_go & w_wr_sel, w_wr_go & ~w_wr_sel};
      rd_gnt    = {w_rd_go & w_rd_sel, w_rd_go & ~w_rd_sel};
   end

   always_comb begin
      wr_last_d     = w_wr_go ? w_wr_sel : wr_last_q;
      rd_last_d     = w_rd_go ? w_rd_sel : rd_last_q;
      ram_wr_enbl_d = w_wr_go;
      ram_wr_addr_d = w_wr_go ? w_wr_addr : ram_wr_addr_q;
      ram_wr_data_d = w_wr_go ? w_wr_data : ram_wr_data_q;
      ram_rd_enbl_d = w_rd_go;
      ram_rd_addr_d = w_rd_go ? w_rd_addr : ram_rd_addr_q;
      rd_own1_d     = w_rd_go ? w_rd_sel : rd_own1_q;
      // ram_rd_enbl_q doubles as the stage-1 valid of the return pipeline.
      rd_valid_d    = {ram_rd_enbl_q & rd_own1_q, ram_rd_enbl_q & ~rd_own1_q};
      rd_hold_d     = (|rd_valid_q) ? ram_rd_data : rd_hold_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_last_q     <= 1'b1;
         rd_last_q     <= 1'b1;
         ram_wr_enbl_q <= 1'b0;
         ram_wr_addr_q <= '0;
         ram_wr_data_q <= '0;
         ram_rd_enbl_q <= 1'b0;
         ram_rd_addr_q <= '0;
         rd_own1_q     <= 1'b0;
         rd_valid_q    <= 2'b00;
         rd_hold_q     <= '0;
      end else begin
         wr_last_q     <= wr_last_d;
         rd_last_q     <= rd_last_d;
         ram_wr_enbl_q <= ram_wr_enbl_d;
         ram_wr_addr_q <= ram_wr_addr_d;
         ram_wr_data_q <= ram_wr_data_d;
         ram_rd_enbl_q <= ram_rd_enbl_d;
         ram_rd_addr_q <= ram_rd_addr_d;
         rd_own1_q     <= rd_own1_d;
         rd_valid_q    <= rd_valid_d;
         rd_hold_q     <= rd_hold_d;
      end
   end

   // RAM data arrives in the same cycle as rd_valid, so it is passed straight through.
   assign rd_valid    = rd_valid_q;
   assign rd_data_o   = (|rd_valid_q) ? ram_rd_data : rd_hold_q;
   assign ram_wr_enbl = ram_wr_enbl_q;
   assign ram_wr_addr = ram_wr_addr_q;
   assign ram_wr_data = ram_wr_data_q;
   assign ram_rd_enbl = ram_rd_enbl_q;
   assign ram_rd_addr = ram_rd_addr_q;

endmodule

`default_nettype wire

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares the write port and the read port of the 256x8 dual-port RAM (`ram_rtl`) between two independent masters. Each port has its own round-robin arbiter. The block registers the RAM command signals and steers read data back to the requester that issued the read. It blocks same-cycle write/read collisions to the same address, so read-after-write ordering holds. The block sits between the requesters and `ram_rtl` and drives all RAM inputs.

## Interface
- DEPTH, 256, number of RAM words
- DWIDTH, 8, data width in bits
- AWIDTH, $clog2(DEPTH), address width (derived, not overridable)

- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- wr_req  in  2  write request; bit i belongs to requester i
- wr_addr_i  in  2*AWIDTH  requester i write address at [i*AWIDTH +: AWIDTH]
- wr_data_i  in  2*DWIDTH  requester i write data at [i*DWIDTH +: DWIDTH]
- wr_gnt  out  2  write grant, one-hot or zero
- rd_req  in  2  read request per requester
- rd_addr_i  in  2*AWIDTH  requester i read address
- rd_gnt  out  2  read grant, one-hot or zero
- rd_valid  out  2  read data valid; bit i marks data for requester i
- rd_data_o  out  DWIDTH  returned read data, qualified by rd_valid
- ram_wr_enbl / ram_wr_addr / ram_wr_data  out  1/AWIDTH/DWIDTH  registered RAM write command
- ram_rd_enbl / ram_rd_addr  out  1/AWIDTH  registered RAM read command
- ram_rd_data  in  DWIDTH  RAM read data, valid one cycle after ram_rd_enbl is sampled

## Operation

**Handshake**
- A requester holds req, addr and data stable until it sees gnt.
- A transfer occurs on the posedge where req[i] & gnt[i] are both high.
- gnt is combinational from req and the arbiter state.

**Write arbitration**
- One request pending: that requester is granted.
- Both pending: grant goes to the requester not granted last (wr_last).
- wr_last updates only on a grant.

**Read arbitration**
- Same round-robin scheme, using an independent pointer rd_last.

**Hazard rule**
- Condition: a write is granted this cycle and the address of the read candidate equals the granted write address.
- Action: rd_gnt = 0 this cycle and rd_last is unchanged. The read is retried the next cycle.

**Command registers**
- On a write grant: ram_wr_enbl <= 1, and ram_wr_addr / ram_wr_data latch the granted requester's fields.
- Without a write grant: ram_wr_enbl <= 0, and addr/data hold.
- The read port uses the same scheme for ram_rd_enbl / ram_rd_addr.

**Read return**
- A 2-stage owner/valid pipeline tracks which requester owns each read.
- Stage 1 is aligned with ram_rd_enbl.
- Stage 2 drives rd_valid[owner] = 1, with rd_data_o = ram_rd_data.
- The other rd_valid bit is 0. rd_data_o holds its last value when rd_valid is zero.

**Reset**
- While rst is high, wr_gnt = rd_gnt = 0.
- On the first clock edge with rst high, these clear to 0: ram_wr_enbl, ram_rd_enbl, ram_wr_addr, ram_wr_data, ram_rd_addr, rd_valid, rd_data_o and the pipeline valids.
- wr_last and rd_last reset to 1, so requester 0 wins the first contention.

**Reset mid-operation**
- In-flight reads are discarded. No rd_valid is produced after rst deasserts for any read granted before reset.
- RAM contents are not cleared by this block.

## Timing
- Cycle N: gnt asserted.
- N+1: RAM command registered and visible on ram_*.
- Write commits at the posedge ending N+1.
- A read granted at N gives rd_valid / rd_data_o during N+2.
- Throughput: one write and one read per cycle, sustained. Back-to-back grants to alternating requesters are supported with no bubbles.
- Hazard stall costs exactly one cycle. The stalled read issues at N+2, after the write commits, and returns the new data.
- A write granted at N-1 and a read granted at N to the same address need no stall. The read returns the new data.

## Test plan
- Reset and first contention:
  - Stimulus: rst high 2 cycles, then wr_req = 11 and rd_req = 11 with different addresses.
  - Response: all outputs 0 during reset; first wr_gnt = 01 and rd_gnt = 01.
- Simple write then read:
  - Stimulus: requester 1 writes 0xA5 to 0x10; then requester 0 reads 0x10.
  - Response: ram_wr_enbl high one cycle after wr_gnt; rd_valid = 01 and rd_data_o = 0xA5 two cycles after rd_gnt.
- Write round-robin:
  - Stimulus: both requesters hold wr_req for 4 cycles.
  - Response: wr_gnt = 01, 10, 01, 10; ram_wr_addr follows each grant one cycle later.
- Same-cycle hazard:
  - Stimulus: requester 0 writes 0x3C to 0x20 while requester 1 reads 0x20 in the same cycle.
  - Response: rd_gnt = 00 that cycle and 10 the next; rd_data_o = 0x3C with rd_valid = 10.
- Interleaved reads:
  - Stimulus: requester 0 reads 0x00 and 0x01 while requester 1 reads 0x02 concurrently.
  - Response: rd_valid owners follow grant order 01, 10, 01, one per cycle; data matches the preloaded contents.
- Reset mid-read:
  - Stimulus: rst asserted one cycle after an rd_gnt.
  - Response: no rd_valid for that read; ram_rd_enbl = 0 after the reset edge.
